// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
// Parity support is controlled by `UART_TX_PARITY_EN (see fifo_uart_tx.sv).
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_LVL     = 1'b0;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status of the UART transmitter.
// master = FIFO/board side, slave = transmitter.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_W = 8
);

  logic              tx_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_re;
  logic              tx;
  logic              busy;

  modport master (
    output tx_en,
    output fifo_empty,
    output fifo_data,
    input  fifo_re,
    input  tx,
    input  busy
  );

  modport slave (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_re,
    output tx,
    output busy
  );

endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while restart is high so every bit starts on a fresh count.
module uart_bit_timer
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned       CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-drain UART transmitter: pops one byte per frame and sends it LSB first.
// Frame is 8N1 by default; defining `UART_TX_PARITY_EN adds an even-parity bit (8E1).
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_uart_tx_if.slave        bus
);

  localparam int unsigned      IDX_W    = cnt_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state_q;
  logic              tx_q;
  logic              busy_q;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  bit_idx_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic pop;
  logic restart;
  logic tick;

  // Gated by rst so no byte is consumed while the block is held in reset.
  assign pop     = (state_q == IDLE) && bus.tx_en && !bus.fifo_empty && !rst;
  assign restart = (state_q == IDLE) || (state_q == LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // tx_q is loaded with the level of the state being entered, so the line
  // changes exactly on the edge that changes state and never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= UART_IDLE_LVL;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          shift_q <= bus.fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_q <= ^bus.fifo_data;
`endif
          state_q <= START;
          tx_q    <= START_LVL;
        end
        START: begin
          if (tick) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= UART_IDLE_LVL;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            tx_q    <= UART_IDLE_LVL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= UART_IDLE_LVL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_re = pop;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;

  // Leaving IDLE on the pop edge makes back-to-back pops impossible.
  a_single_pop : assert property (@(posedge clk) disable iff (rst) pop |=> !pop);
  a_busy_idle  : assert property (@(posedge clk) disable iff (rst) (state_q == IDLE) |-> !busy_q);
  a_tx_idle    : assert property (@(posedge clk) disable iff (rst) (state_q == IDLE) |-> tx_q);

endmodule
